// File: rtl/led_flow_seq.sv
// led_flow_seq: step-driven LED pattern sequencer.
//
// Detects rising edges of a step strobe and, while Run is set, divides them by STEP_DIV.
// Each advance moves the LED pattern one step in the selected mode: rotate left,
// rotate right, ping-pong or blink-all. Wrap_pulse flags the completion of a pattern cycle.
//
// Ports:
//   CLK         system clock, rising edge
//   RSTn        asynchronous active-low reset
//   Step_in     step strobe (only rising edges count)
//   Mode[1:0]   0 shift left, 1 shift right, 2 ping-pong, 3 blink-all
//   Run         1 advance on steps, 0 freeze
//   LED_out     registered LED pattern, bit 0 is the leftmost start LED
//   Wrap_pulse  registered one-cycle cycle-complete flag
module led_flow_seq #(
  parameter int unsigned N_LED    = 4,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Step_in,
  input  logic [1:0]       Mode,
  input  logic             Run,
  output logic [N_LED-1:0] LED_out,
  output logic             Wrap_pulse
);

  localparam int unsigned    CntW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_DIV - 1);

  localparam logic [N_LED-1:0] LedLsb = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0] LedMsb = {1'b1, {(N_LED-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StShl   = 3'd1,
    StShr   = 3'd2,
    StPpUp  = 3'd3,
    StPpDn  = 3'd4,
    StBlink = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             wrap_q, wrap_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             step_q;

  logic             rise;
  logic             acc;
  logic             advance;
  logic             state_valid;
  logic [1:0]       active_mode;
  state_e           load_state;
  logic [N_LED-1:0] load_led;

  // Edge detect and divider.
  always_comb begin
    rise    = Step_in & ~step_q;
    acc     = rise & Run;
    advance = acc && (cnt_q == CntMax);
    cnt_d   = cnt_q;
    if (acc) begin
      cnt_d = advance ? '0 : cnt_q + 1'b1;
    end
  end

  // Mode owning the current state; invalid encodings are flagged for recovery.
  always_comb begin
    state_valid = 1'b1;
    active_mode = 2'd0;
    case (state_q)
      StIdle:         active_mode = 2'd0;
      StShl:          active_mode = 2'd0;
      StShr:          active_mode = 2'd1;
      StPpUp, StPpDn: active_mode = 2'd2;
      StBlink:        active_mode = 2'd3;
      default:        state_valid = 1'b0;
    endcase
  end

  // Start pattern for the requested mode.
  always_comb begin
    load_state = StShl;
    load_led   = LedLsb;
    case (Mode)
      2'd0: begin load_state = StShl;   load_led = LedLsb; end
      2'd1: begin load_state = StShr;   load_led = LedMsb; end
      2'd2: begin load_state = StPpUp;  load_led = LedLsb; end
      default: begin load_state = StBlink; load_led = '1; end
    endcase
  end

  // Pattern FSM next state.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    wrap_d  = 1'b0;
    if (!state_valid) begin
      state_d = StIdle;
      led_d   = '0;
    end else if (advance) begin
      if (state_q == StIdle || Mode != active_mode) begin
        // Fresh start or mode switch: load, never flag a wrap.
        state_d = load_state;
        led_d   = load_led;
      end else begin
        case (state_q)
          StShl: begin
            led_d  = {led_q[N_LED-2:0], led_q[N_LED-1]};
            wrap_d = led_q[N_LED-1];
          end
          StShr: begin
            led_d  = {led_q[0], led_q[N_LED-1:1]};
            wrap_d = led_q[0];
          end
          StPpUp: begin
            led_d = led_q << 1;
            // Turn around as soon as the far end is lit so it is lit only once.
            if (led_q[N_LED-2]) state_d = StPpDn;
          end
          StPpDn: begin
            led_d = led_q >> 1;
            if (led_q[1]) begin
              state_d = StPpUp;
              wrap_d  = 1'b1;
            end
          end
          StBlink: begin
            led_d  = (led_q == '0) ? '1 : '0;
            wrap_d = (led_q == '0);
          end
          default: begin
            state_d = StIdle;
            led_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      led_q   <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      step_q  <= Step_in;
    end
  end

  assign LED_out    = led_q;
  assign Wrap_pulse = wrap_q;

endmodule
